tapeout_spi_port_router: RTL and testbench
==========================================

// Module: tapeout_spi_port_router
// PURPOSE
//  - Shares the SPI stack's single val/rdy Send/Recv pair among num_ports tapeout blocks.
//  - Request path: routes each message from the SPI stack to one port, selected by the address field in the message MSBs.
//  - Response path: round-robin arbitrates port responses back to the SPI stack, tagging each with its port id.
//  - Sits between the SPI stack and the per-block wrappers inside the tapeout top.
// PARAMETERS
//  nbits      32  SPI stack message width; the two minion flow-control bits are already excluded
//  num_ports  3   number of attached blocks, 1..4
//  ab         2   address field width; msg[nbits-1 -: ab] is the port id
//  pw         nbits-ab  payload width (localparam)
// PORTS
//  clk            in   1             clock
//  reset          in   1             asynchronous, active-low reset
//  spi_recv_val   in   1             msg valid from SPI stack send side
//  spi_recv_msg   in   nbits         {addr, payload}
//  spi_recv_rdy   out  1             router can accept
//  spi_send_val   out  1             response valid to SPI stack recv side
//  spi_send_msg   out  nbits         {port id, payload}
//  spi_send_rdy   in   1             SPI stack accepts response
//  req_val        out  num_ports     per-port request valid
//  req_msg        out  num_ports*pw  per-port payload; slice i = bits [i*pw +: pw]
//  req_rdy        in   num_ports     per-port request ready
//  resp_val       in   num_ports     per-port response valid
//  resp_msg       in   num_ports*pw  per-port response payload
//  resp_rdy       out  num_ports     per-port response ready
// BEHAVIOUR
//  - Transfer occurs on a posedge where val&&rdy. reset low: all state cleared immediately, regardless of clk.
//  - While reset is low: every val/rdy output is 0, the RR pointer is 0 and both buffers are empty. Msg outputs are 0.
//  - Request FSM, one-entry registered buffer with states EMPTY and FULL:
//    - EMPTY: spi_recv_rdy=1. On accept, latch {addr,payload} and go to FULL.
//    - FULL: req_val[addr]=1, all other req_val=0, and req_msg slice addr = payload (broadcast on all slices is allowed).
//    - FULL -> EMPTY on req_rdy[addr] unless a new accept occurs in the same cycle.
//    - spi_recv_rdy = EMPTY || req_rdy[addr], so back-to-back messages sustain 1 msg/cycle.
//    - Latency: accept at edge t, req_val visible after edge t, earliest port transfer at edge t+1.
//    - addr >= num_ports: the message is consumed in EMPTY and never presented. Error handling: see CONFIGURATION.
//  - Response FSM, one-entry output register with states EMPTY and FULL, plus round-robin pointer rr (2 bits):
//    - Grant goes to the lowest-numbered valid port, scanning from rr upward with wrap-around.
//    - resp_rdy[g] = (EMPTY || spi_send_rdy); resp_rdy for all non-granted ports = 0.
//    - On grant transfer: latch {g, resp_msg slice g}, set FULL, and set rr = (g+1) mod num_ports.
//    - rr is unchanged when there is no grant.
//    - spi_send_val=FULL. FULL -> EMPTY on spi_send_rdy unless a new grant transfers in the same cycle.
//    - Single requester held valid: 1 response/cycle while spi_send_rdy=1.
//    - Simultaneous valid ports: strictly rotate; no port waits more than num_ports-1 grants.
//  - The request and response paths are independent; simultaneous request and response traffic does not interfere.
//  - Reset mid-transfer: buffered messages are discarded and rr returns to 0; no partial transfer is emitted.
// CONFIGURATION
//  - SPI_PORT_ROUTER_ERR_EN defined:
//    - A message with addr >= num_ports sets a one-bit err_pend flag instead of being silently dropped.
//    - err_pend acts as a highest-priority virtual requester. It outputs {addr, {pw{1'b1}}} and does not advance rr.
//    - spi_recv_rdy is 0 while err_pend=1.
//  - Undefined: out-of-range messages are dropped silently. No err_pend flop exists.
// TESTING
//  - Reset low, then high, idle: spi_recv_rdy=1, spi_send_val=0, req_val=0, resp_rdy=0.
//  - Send 0x4000_00AA (addr 1) with req_rdy=3'b111: req_val=3'b010 for 1 cycle, slice1=0x00AA. Follow with 0x0000_0011 back-to-back -> port0 next cycle.
//  - Hold req_rdy[2]=0 and send 0x8000_0005: spi_recv_rdy=0 after 1 cycle and the msg is held. Release -> delivered, rdy=1.
//  - resp_val=3'b111 with payloads 1,2,3 held and spi_send_rdy=1: outputs 0x0000_0001, 0x4000_0002, 0x8000_0003, then repeat in the same order.
//  - spi_send_rdy=0 with FULL: output stable, resp_rdy=0. Assert reset low mid-stall: spi_send_val drops immediately, rr=0.
//  - Send 0xC000_0123: ERR_EN -> spi_send_msg=0xFFFF_FFFF once; without ERR_EN -> no req_val, no response.

Source files
------------

// File: rtl/tapeout_spi_port_router_if.sv
// tapeout_spi_port_router_if: SPI-stack val/rdy pair and per-port request/response bundles of the port router.
interface tapeout_spi_port_router_if #(
  parameter int nbits = 32,
  parameter int num_ports = 3,
  parameter int ab = 2
);
  localparam int pw = nbits - ab;
  logic                    spi_recv_val;
  logic [nbits-1:0]        spi_recv_msg;
  logic                    spi_recv_rdy;
  logic                    spi_send_val;
  logic [nbits-1:0]        spi_send_msg;
  logic                    spi_send_rdy;
  logic [num_ports-1:0]    req_val;
  logic [num_ports*pw-1:0] req_msg;
  logic [num_ports-1:0]    req_rdy;
  logic [num_ports-1:0]    resp_val;
  logic [num_ports*pw-1:0] resp_msg;
  logic [num_ports-1:0]    resp_rdy;
  modport master (
    input  spi_recv_val, spi_recv_msg, spi_send_rdy, req_rdy, resp_val, resp_msg,
    output spi_recv_rdy, spi_send_val, spi_send_msg, req_val, req_msg, resp_rdy
  );
  modport slave (
    output spi_recv_val, spi_recv_msg, spi_send_rdy, req_rdy, resp_val, resp_msg,
    input  spi_recv_rdy, spi_send_val, spi_send_msg, req_val, req_msg, resp_rdy
  );
endinterface

// File: rtl/tapeout_spi_port_router.sv
// tapeout_spi_port_router: routes SPI-stack requests to ports by address; round-robins port responses back.
// Define SPI_PORT_ROUTER_ERR_EN to answer out-of-range requests with an all-ones error response.
module tapeout_spi_port_router #(
  parameter int nbits = 32,
  parameter int num_ports = 3,
  parameter int ab = 2
) (
  input logic clk,
  input logic reset,
  tapeout_spi_port_router_if.master bus
);
  localparam int pw = nbits - ab;
  localparam int na = 1 << ab;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t req_st, req_nx, rsp_st, rsp_nx;
  logic [ab-1:0] req_addr, in_addr;
  logic [pw-1:0] req_pay, sel;
  logic [na-1:0] rdy_ext;
  logic [3:0] rv_ext;
  logic [1:0] rr, rr_nx, gnt, c;
  logic [nbits-1:0] out_msg, err_msg;
  logic in_ok, req_done, recv_rdy, accept, err_pend, err_go, take, gnt_val, port_go;

  assign in_addr = bus.spi_recv_msg[nbits-1 -: ab];
  assign in_ok = int'(in_addr) < num_ports;
  assign rdy_ext = na'(bus.req_rdy);
  assign req_done = req_st == FULL && rdy_ext[req_addr];
  assign recv_rdy = reset && (req_st == EMPTY || req_done) && !err_pend;
  assign accept = bus.spi_recv_val && recv_rdy;
  assign bus.spi_recv_rdy = recv_rdy;
  assign bus.req_val = req_st == FULL ? num_ports'(1 << req_addr) : '0;
  assign bus.req_msg = {num_ports{req_pay}};

`ifdef SPI_PORT_ROUTER_ERR_EN
  logic [ab-1:0] err_addr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      err_pend <= 1'b0;
      err_addr <= '0;
    end else if (accept && !in_ok) begin
      err_pend <= 1'b1;
      err_addr <= in_addr;
    end else if (err_go) err_pend <= 1'b0;
  assign err_msg = {err_addr, {pw{1'b1}}};
`else
  assign err_pend = 1'b0;
  assign err_msg = '0;
`endif

  // first valid port at or after rr, wrapping; lowest loop index wins
  always_comb begin
    gnt_val = 1'b0;
    gnt = '0;
    c = '0;
    sel = '0;
    for (int k = num_ports - 1; k >= 0; k--) begin
      c = 2'((int'(rr) + k) % num_ports);
      if (rv_ext[c]) begin
        gnt_val = 1'b1;
        gnt = c;
      end
    end
    for (int k = 0; k < num_ports; k++) if (gnt == 2'(k)) sel = bus.resp_msg[k*pw +: pw];
  end

  assign rv_ext = 4'(bus.resp_val);
  assign take = rsp_st == EMPTY || bus.spi_send_rdy;
  assign err_go = err_pend && take;
  assign port_go = reset && !err_pend && gnt_val && take;
  assign bus.resp_rdy = port_go ? num_ports'(1 << gnt) : '0;
  assign bus.spi_send_val = rsp_st == FULL;
  assign bus.spi_send_msg = out_msg;

  always_comb begin
    req_nx = accept && in_ok ? FULL : req_done ? EMPTY : req_st;
    rsp_nx = port_go || err_go ? FULL : bus.spi_send_rdy ? EMPTY : rsp_st;
    rr_nx = port_go ? 2'((int'(gnt) + 1) % num_ports) : rr;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      req_st <= EMPTY;
      req_addr <= '0;
      req_pay <= '0;
    end else begin
      req_st <= req_nx;
      if (accept && in_ok) begin
        req_addr <= in_addr;
        req_pay <= bus.spi_recv_msg[pw-1:0];
      end
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rsp_st <= EMPTY;
      rr <= '0;
      out_msg <= '0;
    end else begin
      rsp_st <= rsp_nx;
      rr <= rr_nx;
      if (err_go) out_msg <= err_msg;
      else if (port_go) out_msg <= {ab'(gnt), sel};
    end
endmodule

// File: tb/tb_tapeout_spi_port_router.sv
// tb_tapeout_spi_port_router: directed and random scoreboard bench for the SPI port router.
module tb_tapeout_spi_port_router;
  localparam int NB = 32, N = 3, AB = 2, PW = NB - AB;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  tapeout_spi_port_router_if #(.nbits(NB), .num_ports(N), .ab(AB)) bus ();
  tapeout_spi_port_router #(.nbits(NB), .num_ports(N), .ab(AB)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed { logic [AB-1:0] port; logic [PW-1:0] pay; } req_t;
  req_t req_exp[$];
  logic [PW-1:0] src[N][$];
  logic [PW-1:0] rsp_exp[N][$];
  int err_exp = 0, n_chk = 0, n_fail = 0, brr = 0;
  bit run = 1'b0;
  logic [NB-1:0] exp_out[6] = '{32'h0000_0001, 32'h4000_0002, 32'h8000_0003,
                                32'h0000_0001, 32'h4000_0002, 32'h8000_0003};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit resp_busy();
    resp_busy = bus.resp_val != 0;
    for (int p = 0; p < N; p++) if (src[p].size() != 0) resp_busy = 1'b1;
  endfunction

  // monitor: a transfer is decided by the values seen at the negedge before the posedge
  always @(negedge clk) begin : mon
    int g, e, id;
    logic [N-1:0] x;
    req_t r;
    logic [PW-1:0] v;
    if (reset) begin
      if (bus.req_val != 0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (bus.req_val[i]) g = i;
        chk("req_onehot", $countones(bus.req_val), 1);
        if (bus.req_rdy[g]) begin
          chk("req_pending", req_exp.size() != 0, 1);
          if (req_exp.size() != 0) begin
            r = req_exp.pop_front();
            chk("req_port", g, r.port);
            chk("req_payload", bus.req_msg[g*PW +: PW], r.pay);
          end
        end
      end
      if (bus.spi_send_val && bus.spi_send_rdy) begin
        id = int'(bus.spi_send_msg[NB-1 -: AB]);
        if (id < N) begin
          chk("resp_pending", rsp_exp[id].size() != 0, 1);
          if (rsp_exp[id].size() != 0) begin
            v = rsp_exp[id].pop_front();
            chk("resp_payload", bus.spi_send_msg[PW-1:0], v);
          end
        end else begin
          chk("err_pending", err_exp > 0, 1);
          chk("err_payload", bus.spi_send_msg[PW-1:0], {PW{1'b1}});
          err_exp--;
        end
      end
      x = bus.resp_val & bus.resp_rdy;
      if (x != 0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (x[i]) g = i;
        chk("resp_onehot", $countones(x), 1);
        e = -1;
        for (int p = 0; p < N; p++)
          if (bus.resp_val[p] && (e < 0 || (p - brr + N) % N < (e - brr + N) % N)) e = p;
        chk("rr_grant", g, e);
        brr = (g + 1) % N;
      end
    end
  end

  task automatic drive_reqs(input int n);
    logic [AB-1:0] a;
    logic [PW-1:0] pay;
    logic acc;
    int gap;
    for (int i = 0; i < n; i++) begin
      a = AB'($urandom_range(0, 3));
      pay = PW'($urandom);
      bus.spi_recv_msg = {a, pay};
      bus.spi_recv_val = 1'b1;
      if (int'(a) < N) req_exp.push_back({a, pay});
`ifdef SPI_PORT_ROUTER_ERR_EN
      else err_exp++;
`endif
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk);
        acc = bus.spi_recv_rdy;
        tick();
      end
      chk("req_accept", acc, 1);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        bus.spi_recv_val = 1'b0;
        repeat (gap) tick();
      end
    end
    bus.spi_recv_val = 1'b0;
  endtask

  task automatic drive_resps(input int cycles);
    logic [N-1:0] x;
    logic [PW-1:0] d;
    for (int c = 0; c < cycles && resp_busy(); c++) begin
      @(negedge clk);
      x = bus.resp_val & bus.resp_rdy;
      tick();
      for (int p = 0; p < N; p++) begin
        if (x[p]) d = src[p].pop_front();
        if (!bus.resp_val[p] || x[p]) bus.resp_val[p] = src[p].size() != 0 && $urandom_range(0, 3) != 0;
        bus.resp_msg[p*PW +: PW] = src[p].size() != 0 ? src[p][0] : '0;
      end
    end
    chk("resp_src_drained", resp_busy(), 0);
  endtask

  initial begin
    logic [PW-1:0] v;
    bus.spi_recv_val = 1'b1; bus.spi_recv_msg = '0; bus.spi_send_rdy = 1'b1;
    bus.req_rdy = '1; bus.resp_val = '1; bus.resp_msg = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_recv_rdy", bus.spi_recv_rdy, 0);
    chk("rst_send_val", bus.spi_send_val, 0);
    chk("rst_send_msg", bus.spi_send_msg, 0);
    chk("rst_req_val", bus.req_val, 0);
    chk("rst_resp_rdy", bus.resp_rdy, 0);
    bus.spi_recv_val = 1'b0; bus.resp_val = '0; bus.resp_msg = '0; bus.spi_send_rdy = 1'b0; bus.req_rdy = '0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("idle_recv_rdy", bus.spi_recv_rdy, 1);
    chk("idle_send_val", bus.spi_send_val, 0);
    chk("idle_req_val", bus.req_val, 0);
    chk("idle_resp_rdy", bus.resp_rdy, 0);
    // addressed delivery, back-to-back
    tick();
    bus.req_rdy = '1; bus.spi_recv_val = 1'b1; bus.spi_recv_msg = 32'h4000_00AA;
    req_exp.push_back({2'd1, 30'hAA});
    tick();
    bus.spi_recv_msg = 32'h0000_0011;
    req_exp.push_back({2'd0, 30'h11});
    @(negedge clk);
    chk("b2b_req_val_p1", bus.req_val, 3'b010);
    chk("b2b_slice1", bus.req_msg[PW +: PW], 30'hAA);
    chk("b2b_recv_rdy", bus.spi_recv_rdy, 1);
    tick();
    bus.spi_recv_val = 1'b0;
    @(negedge clk);
    chk("b2b_req_val_p0", bus.req_val, 3'b001);
    chk("b2b_slice0", bus.req_msg[PW-1:0], 30'h11);
    tick();
    @(negedge clk);
    chk("b2b_req_idle", bus.req_val, 0);
    // backpressure on port 2
    tick();
    bus.req_rdy = 3'b011; bus.spi_recv_val = 1'b1; bus.spi_recv_msg = 32'h8000_0005;
    req_exp.push_back({2'd2, 30'h5});
    tick();
    bus.spi_recv_val = 1'b0;
    @(negedge clk);
    chk("hold_recv_rdy", bus.spi_recv_rdy, 0);
    chk("hold_req_val", bus.req_val, 3'b100);
    tick();
    @(negedge clk);
    chk("hold_req_val2", bus.req_val, 3'b100);
    chk("hold_slice2", bus.req_msg[2*PW +: PW], 30'h5);
    chk("hold_recv_rdy2", bus.spi_recv_rdy, 0);
    tick();
    bus.req_rdy = '1;
    @(negedge clk);
    chk("release_recv_rdy", bus.spi_recv_rdy, 1);
    tick();
    @(negedge clk);
    chk("release_req_idle", bus.req_val, 0);
    // three held requesters rotate
    tick();
    bus.spi_send_rdy = 1'b1;
    bus.resp_msg = {30'd3, 30'd2, 30'd1};
    bus.resp_val = 3'b111;
    for (int p = 0; p < N; p++) repeat (2) rsp_exp[p].push_back(PW'(p + 1));
    #1;
    chk("rot_first_grant", bus.resp_rdy, 3'b001);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) bus.resp_val = '0;
      @(negedge clk);
      chk("rot_send_val", bus.spi_send_val, 1);
      chk("rot_out", bus.spi_send_msg, exp_out[k]);
    end
    tick();
    @(negedge clk);
    chk("rot_drained", bus.spi_send_val, 0);
    // stall, then reset mid-stall
    tick();
    bus.spi_send_rdy = 1'b0; bus.resp_msg = {30'd0, 30'd0, 30'd7}; bus.resp_val = 3'b001;
    tick();
    @(negedge clk);
    chk("stall_send_val", bus.spi_send_val, 1);
    chk("stall_msg", bus.spi_send_msg, 32'h7);
    chk("stall_resp_rdy", bus.resp_rdy, 0);
    tick();
    @(negedge clk);
    chk("stall_msg_stable", bus.spi_send_msg, 32'h7);
    #2 reset = 1'b0;
    #1;
    chk("midrst_send_val", bus.spi_send_val, 0);
    chk("midrst_resp_rdy", bus.resp_rdy, 0);
    req_exp.delete();
    for (int p = 0; p < N; p++) rsp_exp[p].delete();
    brr = 0;
    bus.resp_val = '0; bus.spi_send_rdy = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    bus.resp_msg = {30'h22, 30'h0, 30'h9}; bus.resp_val = 3'b101;
    rsp_exp[0].push_back(30'h9);
    #1;
    chk("midrst_rr_zero", bus.resp_rdy, 3'b001);
    tick();
    bus.resp_val = '0;
    @(negedge clk);
    chk("midrst_out", bus.spi_send_msg, 32'h0000_0009);
    tick();
    // out-of-range address
    tick();
`ifdef SPI_PORT_ROUTER_ERR_EN
    err_exp++;
`endif
    bus.spi_recv_val = 1'b1; bus.spi_recv_msg = 32'hC000_0123;
    tick();
    bus.spi_recv_val = 1'b0;
    @(negedge clk);
    chk("oor_req_val", bus.req_val, 0);
`ifdef SPI_PORT_ROUTER_ERR_EN
    chk("oor_recv_blocked", bus.spi_recv_rdy, 0);
    tick();
    @(negedge clk);
    chk("oor_err_val", bus.spi_send_val, 1);
    chk("oor_err_msg", bus.spi_send_msg, 32'hFFFF_FFFF);
    chk("oor_recv_rdy", bus.spi_recv_rdy, 1);
    tick();
`else
    chk("oor_recv_rdy", bus.spi_recv_rdy, 1);
    chk("oor_send_val", bus.spi_send_val, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("oor_no_resp", bus.spi_send_val, 0);
    chk("oor_no_req", bus.req_val, 0);
`endif
    // random traffic on both paths at once
    tick();
    for (int p = 0; p < N; p++)
      for (int j = 0; j < 40; j++) begin
        v = PW'($urandom);
        src[p].push_back(v);
        rsp_exp[p].push_back(v);
      end
    run = 1'b1;
    fork
      while (run) begin
        tick();
        bus.req_rdy = N'($urandom);
        bus.spi_send_rdy = $urandom_range(0, 3) != 0;
      end
    join_none
    fork
      drive_reqs(300);
      drive_resps(4000);
    join
    run = 1'b0;
    tick();
    #1;
    bus.req_rdy = '1; bus.spi_send_rdy = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      if (req_exp.size() == 0 && err_exp == 0 && rsp_exp[0].size() == 0 &&
          rsp_exp[1].size() == 0 && rsp_exp[2].size() == 0) break;
      tick();
    end
    chk("drain_req", req_exp.size(), 0);
    chk("drain_err", err_exp, 0);
    for (int p = 0; p < N; p++) chk("drain_resp", rsp_exp[p].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
